// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the 16x-oversampling UART receiver.
//   State encodings (IDLE, START, DATA, STOP, BREAK) are kept as plain
//   localparam constants so legacy code comparing against them still works.
//   OVERSAMPLE / MID_SAMPLE / LAST_SAMPLE describe the 16x sample grid.
//   BAUDRATE is the shared default line rate used by the baud divider.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  MID_SAMPLE  = 4'd7;
  localparam logic [3:0]  LAST_SAMPLE = 4'd15;

  localparam int unsigned BAUDRATE = 115200;

endpackage

// File: rtl/uart_rx_16x_sync_ff.sv
// sync_ff: multi-stage flip-flop synchroniser for a single asynchronous input.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset; every stage loads RESET_VAL
//   d      in  asynchronous input
//   q      out synchronised output (last stage)
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 8N1 (by default) UART receiver sampling at 16x baud.
//   clk50m    in  system clock, the only clock
//   reset_n   in  asynchronous active-low reset
//   tick16    in  one-cycle enable at 16x baud, synchronous to clk50m
//   rxd       in  asynchronous serial input, idles high
//   rx_data   out last received byte, held until the next rx_valid
//   rx_valid  out one-cycle pulse per completed frame
//   frame_err out stop bit sampled low; meaningful only with rx_valid
//   busy      out high in every state except IDLE
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk50m,
  input  logic                 reset_n,
  input  logic                 tick16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rxd_s;

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk   (clk50m),
    .rst_n (reset_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitn_d      = bitn_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    // valid and frame_err are pulses: they fall back to 0 on the next clk
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (tick16) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end

        ST_START: begin
          if (cnt_q == MID_SAMPLE) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d = ST_DATA;
              bitn_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_DATA: begin
          if (cnt_q == LAST_SAMPLE) begin
            shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            bitn_d  = bitn_q + 3'd1;
            if (bitn_q == LAST_BIT) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_STOP: begin
          if (cnt_q == LAST_SAMPLE) begin
            cnt_d       = '0;
            rx_data_d   = shreg_q;
            rx_valid_d  = 1'b1;
            frame_err_d = ~rxd_s;
            state_d     = rxd_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_BREAK: begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: directed plus randomized frames against a byte-level model.
// The model is a queue of {frame_err, data} entries pushed by the frame
// sender; a monitor pops one entry per rx_valid pulse.
module tb_uart_rx_16x;

  localparam int BIT_CLKS = 64;

  logic       clk50m;
  logic       reset_n;
  logic       tick16;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int pushed = 0;
  logic [8:0] exp_q[$];

  uart_rx_16x #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk50m    (clk50m),
    .reset_n   (reset_n),
    .tick16    (tick16),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    clk50m = 1'b0;
    forever #10 clk50m = ~clk50m;
  end

  // tick16 every 4th clock, changed on the falling edge
  initial begin
    int n;
    n = 0;
    tick16 = 1'b0;
    forever begin
      @(negedge clk50m);
      tick16 = (n == 3);
      n = (n + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected frame
  initial begin
    logic prev_valid;
    logic [8:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk50m);
      if (reset_n === 1'b1) begin
        if (rx_valid === 1'b1) begin
          valid_cnt++;
          chk("valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
          chk("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
          end
        end else if (frame_err !== 1'b0) begin
          chk("frame_err_idle", {31'd0, frame_err}, 32'd0);
        end
        prev_valid = rx_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk50m);
  endtask

  // Send one frame. hold_bits extra low bit periods follow a low stop bit.
  // abort_bit >= 0 pulses reset mid data bit abort_bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int hold_bits, input int abort_bit);
    if (abort_bit < 0) begin
      exp_q.push_back({~stop, b});
      pushed++;
    end
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        wait_clks(BIT_CLKS / 2);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_data", {24'd0, rx_data}, 32'd0);
        chk("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
        wait_clks(3);
        rxd = 1'b1;
        reset_n = 1'b1;
        return;
      end
      wait_clks(BIT_CLKS);
    end
    rxd = stop;
    wait_clks(BIT_CLKS);
    if (!stop) begin
      wait_clks(hold_bits * BIT_CLKS);
    end
    rxd = 1'b1;
  endtask

  initial begin
    int v0;
    logic [7:0] rb;
    logic rs;

    rxd = 1'b1;
    reset_n = 1'b0;
    wait_clks(5);
    #1;
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;

    // 1. idle line
    wait_clks(200 * 4);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_data", {24'd0, rx_data}, 32'd0);
    chk("idle_no_valid", valid_cnt, 32'd0);

    // 2. clean frame
    v0 = valid_cnt;
    fork
      send_frame(8'hA5, 1'b1, 0, -1);
      begin
        wait_clks(BIT_CLKS * 3);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
      end
    join
    chk("a5_one_valid", valid_cnt - v0, 32'd1);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_data_held", {24'd0, rx_data}, 32'hA5);
    wait_clks(BIT_CLKS);

    // 3. start glitch
    v0 = valid_cnt;
    rxd = 1'b0;
    wait_clks(4 * 4);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_clks(8 * 4);
    chk("glitch_abort", {31'd0, busy}, 32'd0);
    wait_clks(BIT_CLKS * 2);
    chk("glitch_no_valid", valid_cnt - v0, 32'd0);

    // 4. framing error with break, then a clean frame
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 3, -1);
    chk("break_one_valid", valid_cnt - v0, 32'd1);
    wait_clks(BIT_CLKS);
    chk("break_released", {31'd0, busy}, 32'd0);
    send_frame(8'h01, 1'b1, 0, -1);
    wait_clks(BIT_CLKS);
    chk("after_break_valid", valid_cnt - v0, 32'd2);

    // 5. back-to-back frames
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    send_frame(8'h80, 1'b1, 0, -1);
    wait_clks(BIT_CLKS);
    chk("b2b_three_valid", valid_cnt - v0, 32'd3);

    // 6. reset mid-frame, then a clean frame
    v0 = valid_cnt;
    send_frame(8'h77, 1'b1, 0, 4);
    wait_clks(BIT_CLKS * 2);
    chk("abort_no_valid", valid_cnt - v0, 32'd0);
    send_frame(8'h5A, 1'b1, 0, -1);
    wait_clks(BIT_CLKS);
    chk("post_reset_valid", valid_cnt - v0, 32'd1);
    chk("post_reset_data", {24'd0, rx_data}, 32'h5A);

    // Randomized frames with random stop bits and idle gaps
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, int'($urandom_range(1, 2)), -1);
      wait_clks(BIT_CLKS * int'($urandom_range(0, 2)) + BIT_CLKS / 2);
    end

    wait_clks(BIT_CLKS * 2);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("total_valid", valid_cnt, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
